// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_driver
// Brief    : Time-multiplexed common-anode 7-segment scanner with per-frame
//            BCD snapshot, leading-zero blanking and dash glyph for bad codes.
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            sseg,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       C_SEG_OFF = 7'b1111111;
    localparam logic [6:0]       C_SEG_DASH = 7'b0111111;

    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [4*DIGITS-1:0] snap_bcd_q, snap_bcd_d;
    logic [DIGITS-1:0]   snap_dp_q,  snap_dp_d;
    logic [DIGITS-1:0]   an_q,       an_d;
    logic [6:0]          sseg_q,     sseg_d;
    logic                dp_q,       dp_d;
    logic                ft_q,       ft_d;

    logic                w_wrap;
    logic                w_frame_end;
    logic [3:0]          w_digit;
    logic                w_dp_sel;
    logic                w_blank;
    logic                w_zero_run;
    logic [6:0]          w_glyph;

    always_comb begin
        w_wrap      = en && (cnt_q == C_CNT_MAX);
        w_frame_end = w_wrap && (idx_q == C_IDX_MAX);

        cnt_d = cnt_q;
        idx_d = idx_q;
        if (en) begin
            if (w_wrap) begin
                cnt_d = '0;
                idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        snap_bcd_d = w_frame_end ? bcd_in : snap_bcd_q;
        snap_dp_d  = w_frame_end ? dp_in  : snap_dp_q;
        ft_d       = w_frame_end;
    end

    // Walk from the most significant digit down so the running zero flag
    // tells whether the current digit and everything above it are zero.
    always_comb begin
        w_digit    = 4'd0;
        w_dp_sel   = 1'b0;
        w_blank    = 1'b0;
        w_zero_run = 1'b1;
        an_d       = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (snap_bcd_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                w_digit  = snap_bcd_q[4*k +: 4];
                w_dp_sel = snap_dp_q[k];
                w_blank  = blank_lz && (k != 0) && w_zero_run;
                an_d[k]  = 1'b0;
            end
        end
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_glyph = 7'b1000000;
            4'd1:    w_glyph = 7'b1111001;
            4'd2:    w_glyph = 7'b0100100;
            4'd3:    w_glyph = 7'b0110000;
            4'd4:    w_glyph = 7'b0011001;
            4'd5:    w_glyph = 7'b0010010;
            4'd6:    w_glyph = 7'b0000010;
            4'd7:    w_glyph = 7'b1111000;
            4'd8:    w_glyph = 7'b0000000;
            4'd9:    w_glyph = 7'b0010000;
            default: w_glyph = C_SEG_DASH;
        endcase

        if (en) begin
            sseg_d = w_blank ? C_SEG_OFF : w_glyph;
            dp_d   = ~w_dp_sel;
        end else begin
            sseg_d = C_SEG_OFF;
            dp_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            an_q       <= '1;
            sseg_q     <= C_SEG_OFF;
            dp_q       <= 1'b1;
            ft_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            an_q       <= en ? an_d : '1;
            sseg_q     <= sseg_d;
            dp_q       <= dp_d;
            ft_q       <= ft_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign dp         = dp_q;
    assign frame_tick = ft_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_driver
// Brief    : Directed self-checking bench for sseg_scan_driver (4 digits, 4 cycles/digit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_driver;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] c_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    sseg_scan_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        tick();
        while (frame_tick !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        n_tests++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: frame_tick timeout, got %b expected 1", name, frame_tick);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({an, sseg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: an=%b sseg=%b dp=%b ft=%b expected 1111 1111111 1 0",
                     an, sseg, dp, frame_tick);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if ({an, sseg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: an=%b sseg=%b dp=%b expected 1110 1000000 1", an, sseg, dp);
        end
    endtask

    // One edge already consumed since release; the frame tick lands on edge 16.
    task automatic test_scan();
        logic [6:0] e_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        for (int i = 2; i <= 16; i++) begin
            tick();
            n_tests++;
            if (frame_tick !== (i == 16)) begin
                n_fail++;
                $display("FAIL scan_first_tick edge %0d: ft=%b expected %b", i, frame_tick, (i == 16));
            end
        end
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 4; r++) begin
                tick();
                n_tests++;
                if (an !== c_an[d] || sseg !== e_seg[d]) begin
                    n_fail++;
                    $display("FAIL scan d%0d c%0d: an=%b sseg=%b expected %b %b",
                             d, r, an, sseg, c_an[d], e_seg[d]);
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] e_on  [4] = '{7'b1000000, 7'b1111000, 7'b1111111, 7'b1111111};
        logic [6:0] e_off [4] = '{7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000};
        bcd_in = 16'h0070; blank_lz = 1'b1;
        wait_frame("blank_load");
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 4; r++) begin
                tick();
                n_tests++;
                if (an !== c_an[d] || sseg !== e_on[d]) begin
                    n_fail++;
                    $display("FAIL blank_on d%0d: an=%b sseg=%b expected %b %b",
                             d, an, sseg, c_an[d], e_on[d]);
                end
            end
        end
        blank_lz = 1'b0;
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 4; r++) begin
                tick();
                n_tests++;
                if (an !== c_an[d] || sseg !== e_off[d]) begin
                    n_fail++;
                    $display("FAIL blank_off d%0d: an=%b sseg=%b expected %b %b",
                             d, an, sseg, c_an[d], e_off[d]);
                end
            end
        end
    endtask

    task automatic test_invalid();
        logic [6:0] e_seg [4] = '{7'b0010010, 7'b0111111, 7'b1111111, 7'b1111111};
        bcd_in = 16'h00A5; blank_lz = 1'b1;
        wait_frame("invalid_load");
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 4; r++) begin
                tick();
                n_tests++;
                if (an !== c_an[d] || sseg !== e_seg[d]) begin
                    n_fail++;
                    $display("FAIL invalid d%0d: an=%b sseg=%b expected %b %b",
                             d, an, sseg, c_an[d], e_seg[d]);
                end
            end
        end
    endtask

    task automatic test_tearing();
        logic e_dp1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic e_dp2 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bcd_in = 16'h1111; dp_in = 4'b0101;
        wait_frame("tear_load");
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 4; r++) begin
                tick();
                if (d == 2 && r == 0) begin
                    bcd_in = 16'h2222; dp_in = 4'b1010;
                end
                n_tests++;
                if (an !== c_an[d] || sseg !== 7'b1111001 || dp !== e_dp1[d]) begin
                    n_fail++;
                    $display("FAIL tear_old d%0d: an=%b sseg=%b dp=%b expected %b 1111001 %b",
                             d, an, sseg, dp, c_an[d], e_dp1[d]);
                end
            end
        end
        n_tests++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tear_tick: ft=%b expected 1", frame_tick);
        end
        for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 4; r++) begin
                tick();
                n_tests++;
                if (an !== c_an[d] || sseg !== 7'b0100100 || dp !== e_dp2[d]) begin
                    n_fail++;
                    $display("FAIL tear_new d%0d: an=%b sseg=%b dp=%b expected %b 0100100 %b",
                             d, an, sseg, dp, c_an[d], e_dp2[d]);
                end
            end
        end
    endtask

    // Entered on a frame_tick edge with snapshot 2222 loaded.
    task automatic test_enable();
        repeat (9) tick();
        n_tests++;
        if (an !== 4'b1011) begin
            n_fail++;
            $display("FAIL en_pre: an=%b expected 1011", an);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if ({an, sseg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL en_off c%0d: an=%b sseg=%b dp=%b ft=%b expected 1111 1111111 1 0",
                         i, an, sseg, dp, frame_tick);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (an !== 4'b1011 || sseg !== 7'b0100100) begin
                n_fail++;
                $display("FAIL en_resume c%0d: an=%b sseg=%b expected 1011 0100100", i, an, sseg);
            end
        end
        tick();
        n_tests++;
        if (an !== 4'b0111) begin
            n_fail++;
            $display("FAIL en_next_digit: an=%b expected 0111", an);
        end
        repeat (3) tick();
        n_tests++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL en_frame_tick: ft=%b expected 1", frame_tick);
        end
    endtask

    task automatic test_reset_midframe();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if ({an, sseg, dp, frame_tick} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: an=%b sseg=%b dp=%b ft=%b expected 1111 1111111 1 0",
                     an, sseg, dp, frame_tick);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if ({an, sseg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_release: an=%b sseg=%b dp=%b expected 1110 1000000 1", an, sseg, dp);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blanking();
        test_invalid();
        test_tearing();
        test_enable();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
